// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first, optional parity, 1-2 stop bits.
// A one-word holding register lets the next frame start right after the last stop bit.
module uart_tx_cfg #(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_W    = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   output logic              rdy,
   output logic              dout,
   output logic              busy,
   output logic              tx_done
);
   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_e;

   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud
      $error("uart_tx_cfg: BAUD_DIV must be in 2..65535");
   end
   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
      $error("uart_tx_cfg: DATA_W must be in 5..9");
   end

   function automatic logic parity_bit(input logic [DATA_W-1:0] d);
      if (PARITY == 1) begin
         return ~^d;
      end else begin
         return ^d;
      end
   endfunction

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              par_q, par_d;
   logic              dout_q, dout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              baud_wrap_s;
   logic              load_s;

   assign baud_wrap_s = (cnt_q == CNT_W'(BAUD_DIV - 1));

   // Next-state, line value and holding-register logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_d       = par_q;
      dout_d      = dout_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load_s      = 1'b0;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;

      if (state_q != IDLE) begin
         cnt_d = baud_wrap_s ? {CNT_W{1'b0}} : cnt_q + 1'b1;
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end

      if (din_vld && !hold_full_q) begin
         hold_d      = din;
         hold_full_d = 1'b1;
      end else begin
         hold_d      = hold_q;
         hold_full_d = hold_full_q;
      end

      case (state_q)
         IDLE: begin
            load_s = hold_full_q;
         end
         START: begin
            if (baud_wrap_s) begin
               state_d = DATA;
               dout_d  = shift_q[0];
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
               bit_d   = 4'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_wrap_s && bit_q == 4'(DATA_W - 1)) begin
               bit_d = 4'd0;
               if (PARITY != 0) begin
                  state_d = PAR;
                  dout_d  = par_q;
               end else begin
                  state_d = STOP;
                  dout_d  = 1'b1;
               end
            end else if (baud_wrap_s) begin
               dout_d  = shift_q[0];
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
               bit_d   = bit_q + 4'd1;
            end else begin
               state_d = DATA;
            end
         end
         PAR: begin
            if (baud_wrap_s) begin
               state_d = STOP;
               dout_d  = 1'b1;
               bit_d   = 4'd0;
            end else begin
               state_d = PAR;
            end
         end
         STOP: begin
            if (baud_wrap_s && bit_q == 4'(STOP_BITS - 1)) begin
               done_d = 1'b1;
               if (hold_full_q) begin
                  load_s = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else if (baud_wrap_s) begin
               bit_d = bit_q + 4'd1;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
            dout_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      // Parity is frozen at load so later din changes cannot disturb the frame.
      if (load_s) begin
         state_d     = START;
         shift_d     = hold_q;
         par_d       = parity_bit(hold_q);
         hold_full_d = 1'b0;
         dout_d      = 1'b0;
         busy_d      = 1'b1;
         bit_d       = 4'd0;
      end else begin
         par_d = par_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         bit_q       <= 4'd0;
         shift_q     <= {DATA_W{1'b0}};
         hold_q      <= {DATA_W{1'b0}};
         hold_full_q <= 1'b0;
         par_q       <= 1'b0;
         dout_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rdy     = ~hold_full_q;
   assign dout    = dout_q;
   assign busy    = busy_q;
   assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: six configurations driven together and checked every cycle against
// a frame-list model, plus literal bit sequences for the directed frames.
module tb_uart_tx_cfg;
   localparam int NI = 6;

   int bd_c  [NI] = '{4, 4, 4, 4, 3, 2};
   int dw_c  [NI] = '{8, 8, 8, 7, 9, 5};
   int par_c [NI] = '{0, 2, 1, 1, 2, 0};
   int st_c  [NI] = '{1, 1, 1, 2, 2, 1};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] din_a   [NI];
   logic       vld_a   [NI];
   logic       rdy_a   [NI];
   logic       dout_a  [NI];
   logic       busy_a  [NI];
   logic       done_a  [NI];

   int total = 0;
   int bad   = 0;

   logic        m_hf    [NI];
   logic [8:0]  m_hold  [NI];
   logic        m_act   [NI];
   logic        m_done  [NI];
   logic [15:0] m_frame [NI];
   int          m_nb    [NI];
   int          m_idx   [NI];
   int          m_cyc   [NI];

   logic cap_d [NI][100];
   logic cap_t [NI][100];
   logic cap_b [NI][100];

   always #5 clk = ~clk;

   uart_tx_cfg #(.BAUD_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .din(din_a[0][7:0]), .din_vld(vld_a[0]),
      .rdy(rdy_a[0]), .dout(dout_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]));
   uart_tx_cfg #(.BAUD_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .din(din_a[1][7:0]), .din_vld(vld_a[1]),
      .rdy(rdy_a[1]), .dout(dout_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]));
   uart_tx_cfg #(.BAUD_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .din(din_a[2][7:0]), .din_vld(vld_a[2]),
      .rdy(rdy_a[2]), .dout(dout_a[2]), .busy(busy_a[2]), .tx_done(done_a[2]));
   uart_tx_cfg #(.BAUD_DIV(4), .DATA_W(7), .PARITY(1), .STOP_BITS(2)) u3 (
      .clk(clk), .rst_n(rst_n), .din(din_a[3][6:0]), .din_vld(vld_a[3]),
      .rdy(rdy_a[3]), .dout(dout_a[3]), .busy(busy_a[3]), .tx_done(done_a[3]));
   uart_tx_cfg #(.BAUD_DIV(3), .DATA_W(9), .PARITY(2), .STOP_BITS(2)) u4 (
      .clk(clk), .rst_n(rst_n), .din(din_a[4][8:0]), .din_vld(vld_a[4]),
      .rdy(rdy_a[4]), .dout(dout_a[4]), .busy(busy_a[4]), .tx_done(done_a[4]));
   uart_tx_cfg #(.BAUD_DIV(2), .DATA_W(5), .PARITY(0), .STOP_BITS(1)) u5 (
      .clk(clk), .rst_n(rst_n), .din(din_a[5][4:0]), .din_vld(vld_a[5]),
      .rdy(rdy_a[5]), .dout(dout_a[5]), .busy(busy_a[5]), .tx_done(done_a[5]));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
      end
   endtask

   // Frame as a bit list: start, data LSB first, parity from a ones count, stop bits.
   task automatic start_frame(input int i);
      int          ones;
      int          p;
      logic [15:0] f;
      ones = 0;
      f    = 16'h0000;
      for (int k = 0; k < dw_c[i]; k++) begin
         f[1 + k] = m_hold[i][k];
         ones += int'(m_hold[i][k]);
      end
      p = 1 + dw_c[i];
      if (par_c[i] == 1) begin
         f[p] = (ones % 2 == 0);
         p++;
      end else if (par_c[i] == 2) begin
         f[p] = (ones % 2 == 1);
         p++;
      end
      for (int s = 0; s < st_c[i]; s++) begin
         f[p] = 1'b1;
         p++;
      end
      m_frame[i] = f;
      m_nb[i]    = p;
      m_idx[i]   = 0;
      m_cyc[i]   = bd_c[i];
      m_act[i]   = 1'b1;
      m_hf[i]    = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs the DUTs just sampled.
   task automatic model_step();
      logic hf_old;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_hf[i]   = 1'b0;
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_idx[i]  = 0;
         end else begin
            hf_old    = m_hf[i];
            m_done[i] = 1'b0;
            if (m_act[i]) begin
               m_cyc[i]--;
               if (m_cyc[i] == 0) begin
                  m_idx[i]++;
                  if (m_idx[i] == m_nb[i]) begin
                     m_done[i] = 1'b1;
                     m_act[i]  = 1'b0;
                  end else begin
                     m_cyc[i] = bd_c[i];
                  end
               end
            end
            if (!m_act[i] && hf_old) start_frame(i);
            if (vld_a[i] && !hf_old) begin
               m_hf[i]   = 1'b1;
               m_hold[i] = din_a[i] & 9'((1 << dw_c[i]) - 1);
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] e;
      logic [3:0] g;
      for (int i = 0; i < NI; i++) begin
         e = {m_act[i] ? m_frame[i][m_idx[i]] : 1'b1, m_act[i], m_done[i], ~m_hf[i]};
         g = {dout_a[i], busy_a[i], done_a[i], rdy_a[i]};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL cycle inst%0d t=%0t {dout,busy,tx_done,rdy} got=%b expected=%b", i, $time, g, e);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      compare_all();
   endtask

   task automatic capture(input int t);
      for (int i = 0; i < NI; i++) begin
         cap_d[i][t] = dout_a[i];
         cap_t[i][t] = done_a[i];
         cap_b[i][t] = busy_a[i];
      end
   endtask

   function automatic int first_done(input int i, input int n);
      for (int t = 0; t < n; t++) if (cap_t[i][t]) return t;
      return -1;
   endfunction

   function automatic int count_done(input int i, input int n);
      int c = 0;
      for (int t = 0; t < n; t++) c += int'(cap_t[i][t]);
      return c;
   endfunction

   initial begin
      logic [10:0] seq;
      logic [7:0]  w;
      int          pulses;
      int          frames [NI];

      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         vld_a[i]  = 1'b0;
         din_a[i]  = 9'h000;
         frames[i] = 0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("idle {dout,rdy,busy}", {29'd0, dout_a[0], rdy_a[0], busy_a[0]}, 32'h6);

      // Directed frames on four configurations at once.
      din_a[0] = 9'h0A5; din_a[1] = 9'h007; din_a[2] = 9'h007; din_a[3] = 9'h041;
      for (int i = 0; i < 4; i++) vld_a[i] = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) vld_a[i] = 1'b0;
      for (int t = 0; t < 48; t++) begin
         tick();
         capture(t);
      end
      seq = 11'h000;
      for (int k = 0; k < 10; k++) seq[k] = cap_d[0][4 * k + 1];
      chk("8N1 A5 bit sequence", {21'd0, seq}, 32'b1101001010);
      chk("8N1 tx_done cycle", first_done(0, 48), 40);
      chk("8N1 busy falls with tx_done", {30'd0, cap_b[0][39], cap_b[0][40]}, 32'h2);
      chk("even parity bit of 07", {31'd0, cap_d[1][37]}, 32'h1);
      chk("odd parity bit of 07", {31'd0, cap_d[2][37]}, 32'h0);
      chk("8E1 frame length", first_done(1, 48), 44);
      chk("8O1 frame length", first_done(2, 48), 44);
      for (int k = 0; k < 11; k++) seq[k] = cap_d[3][4 * k + 1];
      chk("7O2 41 bit sequence", {21'd0, seq}, 32'b11110000010);
      chk("7O2 frame length", first_done(3, 48), 44);
      repeat (4) tick();

      // Back-to-back: second word as soon as rdy rises, third word while rdy is low.
      din_a[0] = 9'h055; vld_a[0] = 1'b1;
      tick();
      vld_a[0] = 1'b0;
      for (int t = 0; t < 100; t++) begin
         tick();
         capture(t);
         if (t == 0) begin
            chk("rdy high after shifter load", {31'd0, rdy_a[0]}, 32'h1);
            din_a[0] = 9'h0AA; vld_a[0] = 1'b1;
         end else if (t == 1) begin
            chk("rdy low while hold full", {31'd0, rdy_a[0]}, 32'h0);
            din_a[0] = 9'h033;
         end else if (t == 6) begin
            vld_a[0] = 1'b0;
         end
      end
      chk("b2b frames sent", count_done(0, 100), 2);
      chk("b2b first tx_done", first_done(0, 100), 40);
      chk("b2b stop then start, no gap", {30'd0, cap_d[0][39], cap_d[0][40]}, 32'h2);
      chk("b2b busy held across frames", {31'd0, cap_b[0][40]}, 32'h1);
      w = 8'h00;
      for (int k = 0; k < 8; k++) w[k] = cap_d[0][4 * (k + 1) + 1];
      chk("b2b first word", {24'd0, w}, 32'h55);
      for (int k = 0; k < 8; k++) w[k] = cap_d[0][40 + 4 * (k + 1) + 1];
      chk("b2b second word", {24'd0, w}, 32'hAA);

      // Reset in the middle of a frame truncates it.
      din_a[0] = 9'h0F0; vld_a[0] = 1'b1;
      tick();
      vld_a[0] = 1'b0;
      repeat (10) tick();
      chk("mid-frame busy before reset", {31'd0, busy_a[0]}, 32'h1);
      rst_n = 1'b0;
      #1;
      model_step();
      chk("async reset {dout,busy,tx_done,rdy}",
          {28'd0, dout_a[0], busy_a[0], done_a[0], rdy_a[0]}, 32'h9);
      repeat (3) tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int t = 0; t < 60; t++) begin
         tick();
         pulses += int'(done_a[0]);
      end
      chk("no tx_done after truncated frame", pulses, 0);

      // Random traffic on every configuration.
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < NI; i++) begin
            vld_a[i] = ($urandom_range(0, 3) != 0);
            din_a[i] = 9'($urandom);
         end
         tick();
         for (int i = 0; i < NI; i++) frames[i] += int'(done_a[i]);
      end
      for (int i = 0; i < NI; i++) begin
         vld_a[i] = 1'b0;
         chk($sformatf("random frames inst%0d", i), {31'd0, frames[i] >= 20}, 32'h1);
      end
      repeat (60) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
